// File: rtl/ibuf_issue_arb.sv
// ibuf_issue_arb: round-robin issue scheduler between per-slot instruction
// buffers and one shared dispatch port. Eligible requesters must be valid,
// must not be stalled by the scoreboard and must be under their in-flight
// limit. The winner is registered into a single-entry valid/ready stage.
// Per-requester outstanding counts are released by commit returns.
//
// Optional build macro IBUF_ISSUE_ARB_PERF_EN adds three free-running
// 32-bit performance counters (stall, backpressure, issued).
module ibuf_issue_arb #(
   parameter  int NUM_REQS = 4,
   parameter  int DATAW    = 64,
   parameter  int MAX_OUT  = 4,
   localparam int IDXW     = $clog2(NUM_REQS),
   localparam int CNTW     = $clog2(MAX_OUT + 1)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQS-1:0]       req_valid,
   input  logic [NUM_REQS*DATAW-1:0] req_data,
   output logic [NUM_REQS-1:0]       req_ready,
   input  logic [NUM_REQS-1:0]       stall_mask,
   output logic                      out_valid,
   output logic [DATAW-1:0]          out_data,
   output logic [IDXW-1:0]           out_idx,
   input  logic                      out_ready,
   input  logic                      commit_valid,
   input  logic [IDXW-1:0]           commit_idx,
   output logic [NUM_REQS-1:0]       full_mask,
   output logic                      commit_err
`ifdef IBUF_ISSUE_ARB_PERF_EN
   ,
   output logic [31:0]               perf_stall_cycles,
   output logic [31:0]               perf_backpressure_cycles,
   output logic [31:0]               perf_issued
`endif
);

   // Unpacked view of the flat payload bus, one entry per requester.
   logic [DATAW-1:0]    req_data_a [NUM_REQS];

   // Output stage and arbitration pointer state.
   logic                out_valid_q, out_valid_d;
   logic [DATAW-1:0]    out_data_q,  out_data_d;
   logic [IDXW-1:0]     out_idx_q,   out_idx_d;
   logic [IDXW-1:0]     rr_ptr_q,    rr_ptr_d;

   // Outstanding-instruction bookkeeping.
   logic [CNTW-1:0]     cnt_q [NUM_REQS];
   logic [CNTW-1:0]     cnt_d [NUM_REQS];
   logic [NUM_REQS-1:0] full_q, full_d;
   logic                err_q, err_d;

   // Arbitration results.
   logic                load;
   logic [NUM_REQS-1:0] eligible;
   logic                any_elig;
   logic                grant;
   logic [IDXW-1:0]     win_idx;
   logic [IDXW-1:0]     win_next;
   int                  pos;
   logic                inc_c, dec_c;

   for (genvar g = 0; g < NUM_REQS; g++) begin : g_unpack
      assign req_data_a[g] = req_data[g*DATAW +: DATAW];
   end

   // The output register can accept a new instruction when empty or draining.
   assign load = !out_valid_q || out_ready;

   // A requester is eligible only on its registered count; same-cycle commits
   // do not open a slot until the next cycle.
   always_comb begin
      eligible = '0;
      for (int i = 0; i < NUM_REQS; i++) begin
         eligible[i] = req_valid[i] && !stall_mask[i] && (cnt_q[i] < CNTW'(MAX_OUT));
      end
   end

   // Round-robin search starting at rr_ptr, wrapping modulo NUM_REQS.
   always_comb begin
      any_elig = 1'b0;
      win_idx  = '0;
      pos      = 0;
      for (int k = 0; k < NUM_REQS; k++) begin
         pos = (int'(rr_ptr_q) + k) % NUM_REQS;
         if (!any_elig && eligible[pos]) begin
            any_elig = 1'b1;
            win_idx  = IDXW'(pos);
         end
      end
   end

   // Grant is suppressed while reset is asserted so no buffer pops in reset.
   assign grant    = reset && load && any_elig;
   assign win_next = (win_idx == IDXW'(NUM_REQS - 1)) ? '0 : win_idx + IDXW'(1);

   // One-hot pop to the winning buffer.
   always_comb begin
      req_ready = '0;
      if (grant) begin
         req_ready[win_idx] = 1'b1;
      end
   end

   // Next state of the output stage and the round-robin pointer.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_idx_d   = out_idx_q;
      rr_ptr_d    = rr_ptr_q;
      if (load) begin
         if (any_elig) begin
            out_valid_d = 1'b1;
            out_data_d  = req_data_a[win_idx];
            out_idx_d   = win_idx;
            rr_ptr_d    = win_next;
         end else begin
            out_valid_d = 1'b0;
         end
      end
   end

   // Per-requester counts: grant increments, commit decrements, both cancel.
   always_comb begin
      err_d = err_q;
      inc_c = 1'b0;
      dec_c = 1'b0;
      for (int i = 0; i < NUM_REQS; i++) begin
         inc_c    = grant && (win_idx == IDXW'(i));
         dec_c    = commit_valid && (commit_idx == IDXW'(i));
         cnt_d[i] = cnt_q[i];
         if (inc_c && !dec_c) begin
            cnt_d[i] = cnt_q[i] + CNTW'(1);
         end else if (dec_c && !inc_c) begin
            if (cnt_q[i] == '0) begin
               err_d = 1'b1;
            end else begin
               cnt_d[i] = cnt_q[i] - CNTW'(1);
            end
         end
         full_d[i] = (cnt_d[i] == CNTW'(MAX_OUT));
      end
   end

   // Output stage and arbitration pointer registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_idx_q   <= '0;
         rr_ptr_q    <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_idx_q   <= out_idx_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   // Outstanding counts, registered full flags and sticky commit error.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_REQS; i++) begin
            cnt_q[i] <= '0;
         end
         full_q <= '0;
         err_q  <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_REQS; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         full_q <= full_d;
         err_q  <= err_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign out_idx    = out_idx_q;
   assign full_mask  = full_q;
   assign commit_err = err_q;

`ifdef IBUF_ISSUE_ARB_PERF_EN
   logic [31:0] perf_stall_q, perf_bp_q, perf_iss_q;

   // Free-running event counters; they wrap naturally at 2^32.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         perf_stall_q <= '0;
         perf_bp_q    <= '0;
         perf_iss_q   <= '0;
      end else begin
         if ((|req_valid) && load && !grant) begin
            perf_stall_q <= perf_stall_q + 32'd1;
         end
         if (out_valid_q && !out_ready) begin
            perf_bp_q <= perf_bp_q + 32'd1;
         end
         if (grant) begin
            perf_iss_q <= perf_iss_q + 32'd1;
         end
      end
   end

   assign perf_stall_cycles        = perf_stall_q;
   assign perf_backpressure_cycles = perf_bp_q;
   assign perf_issued              = perf_iss_q;
`else
   // Performance counters compiled out: no extra state or ports.
`endif

endmodule

// File: tb/tb_ibuf_issue_arb.sv
// Directed, table-driven bench for ibuf_issue_arb (NUM_REQS=4, DATAW=64,
// MAX_OUT=4), plus hand-written reset sequences.
module tb_ibuf_issue_arb;

   logic         clk;
   logic         reset;
   logic [3:0]   req_valid;
   logic [255:0] req_data;
   logic [3:0]   req_ready;
   logic [3:0]   stall_mask;
   logic         out_valid;
   logic [63:0]  out_data;
   logic [1:0]   out_idx;
   logic         out_ready;
   logic         commit_valid;
   logic [1:0]   commit_idx;
   logic [3:0]   full_mask;
   logic         commit_err;

   int checks   = 0;
   int failures = 0;

   ibuf_issue_arb #(.NUM_REQS(4), .DATAW(64), .MAX_OUT(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_ready    (req_ready),
      .stall_mask   (stall_mask),
      .out_valid    (out_valid),
      .out_data     (out_data),
      .out_idx      (out_idx),
      .out_ready    (out_ready),
      .commit_valid (commit_valid),
      .commit_idx   (commit_idx),
      .full_mask    (full_mask),
      .commit_err   (commit_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [3:0] rv;
      logic [3:0] sm;
      logic       ordy;
      logic       cv;
      logic [1:0] cidx;
      logic [3:0] e_rdy;
      logic       e_ov;
      logic [1:0] e_idx;
      logic [3:0] e_full;
      logic       e_err;
   } vec_t;

   vec_t vt[$];

   function automatic logic [63:0] pat(input int idx);
      return {32'hC0DE_0000 + 32'(idx), 32'h5A5A_0000 + 32'(idx * 17)};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic add(input logic [3:0] rv, input logic [3:0] sm, input logic ordy,
                      input logic cv, input logic [1:0] cidx, input logic [3:0] e_rdy,
                      input logic e_ov, input logic [1:0] e_idx, input logic [3:0] e_full,
                      input logic e_err);
      vec_t v;
      v.rv = rv; v.sm = sm; v.ordy = ordy; v.cv = cv; v.cidx = cidx;
      v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_idx = e_idx; v.e_full = e_full; v.e_err = e_err;
      vt.push_back(v);
   endtask

   initial begin
      // rv    sm    rdy cv cidx | e_rdy ov idx full  err
      // Round robin with matching commits: 0,1,2,3,0,1
      add(4'b1111, 4'b0000, 1, 0, 0, 4'b0001, 1, 0, 4'b0000, 0);   // v0
      add(4'b1111, 4'b0000, 1, 1, 0, 4'b0010, 1, 1, 4'b0000, 0);
      add(4'b1111, 4'b0000, 1, 1, 1, 4'b0100, 1, 2, 4'b0000, 0);
      add(4'b1111, 4'b0000, 1, 1, 2, 4'b1000, 1, 3, 4'b0000, 0);
      add(4'b1111, 4'b0000, 1, 1, 3, 4'b0001, 1, 0, 4'b0000, 0);
      add(4'b1111, 4'b0000, 1, 1, 0, 4'b0010, 1, 1, 4'b0000, 0);   // v5
      add(4'b0000, 4'b0000, 1, 1, 1, 4'b0000, 0, 0, 4'b0000, 0);   // idle drains output
      // Only requester 2: four grants then full
      add(4'b0100, 4'b0000, 1, 0, 0, 4'b0100, 1, 2, 4'b0000, 0);   // v7
      add(4'b0100, 4'b0000, 1, 0, 0, 4'b0100, 1, 2, 4'b0000, 0);
      add(4'b0100, 4'b0000, 1, 0, 0, 4'b0100, 1, 2, 4'b0000, 0);
      add(4'b0100, 4'b0000, 1, 0, 0, 4'b0100, 1, 2, 4'b0100, 0);   // v10
      add(4'b0100, 4'b0000, 1, 0, 0, 4'b0000, 0, 0, 4'b0100, 0);
      add(4'b0100, 4'b0000, 1, 1, 2, 4'b0000, 0, 0, 4'b0000, 0);   // commit frees next cycle
      add(4'b0100, 4'b0000, 1, 0, 0, 4'b0100, 1, 2, 4'b0100, 0);   // exactly one more
      add(4'b0100, 4'b0000, 1, 0, 0, 4'b0000, 0, 0, 4'b0100, 0);
      add(4'b0000, 4'b0000, 1, 1, 2, 4'b0000, 0, 0, 4'b0000, 0);   // v15 drain cnt2
      add(4'b0000, 4'b0000, 1, 1, 2, 4'b0000, 0, 0, 4'b0000, 0);
      add(4'b0000, 4'b0000, 1, 1, 2, 4'b0000, 0, 0, 4'b0000, 0);
      add(4'b0000, 4'b0000, 1, 1, 2, 4'b0000, 0, 0, 4'b0000, 0);
      // Requester 1: same-cycle grant and commit at cnt=2 leaves cnt at 2
      add(4'b0010, 4'b0000, 1, 0, 0, 4'b0010, 1, 1, 4'b0000, 0);   // v19 cnt1=1
      add(4'b0010, 4'b0000, 1, 0, 0, 4'b0010, 1, 1, 4'b0000, 0);   // cnt1=2
      add(4'b0010, 4'b0000, 1, 1, 1, 4'b0010, 1, 1, 4'b0000, 0);   // cnt1 stays 2
      add(4'b0010, 4'b0000, 1, 0, 0, 4'b0010, 1, 1, 4'b0000, 0);   // cnt1=3
      add(4'b0010, 4'b0000, 1, 0, 0, 4'b0010, 1, 1, 4'b0010, 0);   // cnt1=4
      add(4'b0010, 4'b0000, 1, 0, 0, 4'b0000, 0, 0, 4'b0010, 0);
      add(4'b0000, 4'b0000, 1, 1, 1, 4'b0000, 0, 0, 4'b0000, 0);   // v25 drain cnt1
      add(4'b0000, 4'b0000, 1, 1, 1, 4'b0000, 0, 0, 4'b0000, 0);
      add(4'b0000, 4'b0000, 1, 1, 1, 4'b0000, 0, 0, 4'b0000, 0);
      add(4'b0000, 4'b0000, 1, 1, 1, 4'b0000, 0, 0, 4'b0000, 0);
      // Commit to empty requester 3: sticky error, count stays 0
      add(4'b0000, 4'b0000, 1, 1, 3, 4'b0000, 0, 0, 4'b0000, 1);   // v29
      add(4'b1000, 4'b0000, 1, 0, 0, 4'b1000, 1, 3, 4'b0000, 1);
      add(4'b1000, 4'b0000, 1, 0, 0, 4'b1000, 1, 3, 4'b0000, 1);
      add(4'b1000, 4'b0000, 1, 0, 0, 4'b1000, 1, 3, 4'b0000, 1);
      add(4'b1000, 4'b0000, 1, 0, 0, 4'b1000, 1, 3, 4'b1000, 1);   // four grants fill it
      add(4'b1000, 4'b0000, 1, 0, 0, 4'b0000, 0, 0, 4'b1000, 1);
      add(4'b0000, 4'b0000, 1, 1, 3, 4'b0000, 0, 0, 4'b0000, 1);   // v35 drain cnt3
      add(4'b0000, 4'b0000, 1, 1, 3, 4'b0000, 0, 0, 4'b0000, 1);
      add(4'b0000, 4'b0000, 1, 1, 3, 4'b0000, 0, 0, 4'b0000, 1);
      add(4'b0000, 4'b0000, 1, 1, 3, 4'b0000, 0, 0, 4'b0000, 1);
      // Stall mask 0011: alternate 2,3 then resume at pointer
      add(4'b1111, 4'b0011, 1, 0, 0, 4'b0100, 1, 2, 4'b0000, 1);   // v39
      add(4'b1111, 4'b0011, 1, 0, 0, 4'b1000, 1, 3, 4'b0000, 1);
      add(4'b1111, 4'b0011, 1, 0, 0, 4'b0100, 1, 2, 4'b0000, 1);
      add(4'b1111, 4'b0011, 1, 0, 0, 4'b1000, 1, 3, 4'b0000, 1);
      add(4'b1111, 4'b0000, 1, 0, 0, 4'b0001, 1, 0, 4'b0000, 1);   // v43
      add(4'b1111, 4'b0000, 1, 0, 0, 4'b0010, 1, 1, 4'b0000, 1);
      // Backpressure for three cycles: hold idx 1, no pops
      add(4'b1111, 4'b0000, 0, 0, 0, 4'b0000, 1, 1, 4'b0000, 1);   // v45
      add(4'b1111, 4'b0000, 0, 0, 0, 4'b0000, 1, 1, 4'b0000, 1);
      add(4'b1111, 4'b0000, 0, 0, 0, 4'b0000, 1, 1, 4'b0000, 1);
      add(4'b1111, 4'b0000, 1, 0, 0, 4'b0100, 1, 2, 4'b0000, 1);   // resumes at 2
      add(4'b1111, 4'b0000, 1, 0, 0, 4'b1000, 1, 3, 4'b0000, 1);   // v49

      for (int i = 0; i < 4; i++) req_data[i*64 +: 64] = pat(i);

      // Reset state, with requests already presented
      reset        = 1'b0;
      req_valid    = 4'b1111;
      stall_mask   = 4'b0000;
      out_ready    = 1'b1;
      commit_valid = 1'b0;
      commit_idx   = 2'd0;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("rst_req_ready", 64'(req_ready), 64'h0);
      chk("rst_out_valid", 64'(out_valid), 64'h0);
      chk("rst_out_data", out_data, 64'h0);
      chk("rst_out_idx", 64'(out_idx), 64'h0);
      chk("rst_full_mask", 64'(full_mask), 64'h0);
      chk("rst_commit_err", 64'(commit_err), 64'h0);
      reset = 1'b1;

      // Table: inputs driven 1 after the edge, grant checked 2 after, outputs 1 after next edge
      for (int i = 0; i < vt.size(); i++) begin
         req_valid    = vt[i].rv;
         stall_mask   = vt[i].sm;
         out_ready    = vt[i].ordy;
         commit_valid = vt[i].cv;
         commit_idx   = vt[i].cidx;
         #1;
         chk($sformatf("v%0d_req_ready", i), 64'(req_ready), 64'(vt[i].e_rdy));
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_out_valid", i), 64'(out_valid), 64'(vt[i].e_ov));
         if (vt[i].e_ov) begin
            chk($sformatf("v%0d_out_idx", i), 64'(out_idx), 64'(vt[i].e_idx));
            chk($sformatf("v%0d_out_data", i), out_data, pat(int'(vt[i].e_idx)));
         end
         chk($sformatf("v%0d_full_mask", i), 64'(full_mask), 64'(vt[i].e_full));
         chk($sformatf("v%0d_commit_err", i), 64'(commit_err), 64'(vt[i].e_err));
      end

      // Mid-stream asynchronous reset: outputs clear before the next edge
      commit_valid = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      chk("async_out_valid", 64'(out_valid), 64'h0);
      chk("async_out_data", out_data, 64'h0);
      chk("async_full_mask", 64'(full_mask), 64'h0);
      chk("async_commit_err", 64'(commit_err), 64'h0);
      chk("async_req_ready", 64'(req_ready), 64'h0);
      @(posedge clk);
      #1;
      reset = 1'b1;

      // Counts were cleared: requester 2 (cnt 3 before reset) gets four grants again
      req_valid  = 4'b0100;
      stall_mask = 4'b0000;
      out_ready  = 1'b1;
      for (int g = 0; g < 4; g++) begin
         #1;
         chk($sformatf("post_rst_rdy%0d", g), 64'(req_ready), 64'h4);
         @(posedge clk);
         #1;
         chk($sformatf("post_rst_idx%0d", g), 64'(out_idx), 64'h2);
      end
      chk("post_rst_full", 64'(full_mask), 64'h4);
      chk("post_rst_err", 64'(commit_err), 64'h0);
      #1;
      chk("post_rst_blocked", 64'(req_ready), 64'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
